// File: rtl/pipe_mem.sv
// rtl/pipe_mem.sv - MEM pipeline stage with req/ack data-memory port; optional PIPE_MEM_ALIGN_CHK_EN
module pipe_mem #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exe_mem_validto,
    output logic          mem_allowin,
    input  logic          wb_allowin,
    output logic          mem_wb_validto,
    input  logic [31:0]   alu_result_in,
    input  logic [31:0]   rt_in,
    input  logic [4:0]    rdc_in,
    input  logic [1:0]    rd_mux_sel_in,
    input  logic          dmem_we_in,
    input  logic          lw_instr_in,
    input  logic          rf_we_in,
    input  logic          bypass_rdc_valid_in,
    input  logic [31:0]   lo_in,
    input  logic [31:0]   hi_in,
    output logic          dmem_req,
    output logic          dmem_wr,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata,
    output logic [31:0]   rd_data,
    output logic [4:0]    rdc_mem,
    output logic          rf_we,
    output logic [31:0]   bypass_mem,
    output logic          mem_rdc_valid,
`ifdef PIPE_MEM_ALIGN_CHK_EN
    output logic          mem_adel,
`endif
    output logic          mem_load_pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mem_valid;
    logic        mem_ready_go;
    logic        capture;
    logic        transfer;
    logic        access;
    logic        access_in;
    logic        adel_in;

    logic [31:0] alu_result_r;
    logic [31:0] rt_r;
    logic [4:0]  rdc_r;
    logic [1:0]  rd_mux_sel_r;
    logic        dmem_we_r;
    logic        lw_instr_r;
    logic        rf_we_r;
    logic        bypass_rdc_valid_r;
    logic [31:0] lo_r;
    logic [31:0] hi_r;
    logic [31:0] load_buf;
    logic        adel_r;

    assign access       = lw_instr_r | dmem_we_r;
    assign access_in    = lw_instr_in | dmem_we_in;
    assign mem_ready_go = !access || (state == DONE);
    assign mem_allowin  = !mem_valid || (mem_ready_go && wb_allowin);
    assign mem_wb_validto = mem_valid && mem_ready_go;
    assign capture      = exe_mem_validto && mem_allowin;
    assign transfer     = mem_wb_validto && wb_allowin;

`ifdef PIPE_MEM_ALIGN_CHK_EN
    // A misaligned access never reaches memory; it completes immediately with an exception flag.
    assign adel_in  = access_in && (alu_result_in[1:0] != 2'b00);
    assign mem_adel = adel_r;
`else
    assign adel_in  = 1'b0;
`endif

    // Stage occupancy: refilled (or emptied) whenever the stage may accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= exe_mem_validto;
        end
    end

    // Payload capture; deliberately unreset since mem_valid qualifies every use.
    always_ff @(posedge clk) begin
        if (capture) begin
            alu_result_r       <= alu_result_in;
            rt_r               <= rt_in;
            rdc_r              <= rdc_in;
            rd_mux_sel_r       <= rd_mux_sel_in;
            dmem_we_r          <= dmem_we_in;
            lw_instr_r         <= lw_instr_in;
            rf_we_r            <= rf_we_in;
            bypass_rdc_valid_r <= bypass_rdc_valid_in;
            lo_r               <= lo_in;
            hi_r               <= hi_in;
        end
    end

    // Address-error flag follows the instruction through MEM and drops when it leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_r <= 1'b0;
        end else if (capture) begin
            adel_r <= adel_in;
        end else if (transfer) begin
            adel_r <= 1'b0;
        end
    end

    // Read data is latched only on the completing ack of a read.
    always_ff @(posedge clk) begin
        if (state == REQ && dmem_ack && !dmem_we_r) begin
            load_buf <= dmem_rdata;
        end
    end

    // Memory-access FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a capture always restarts the FSM; otherwise wait for ack, then for WB.
    always_comb begin
        state_nxt = state;
        if (capture) begin
            if (adel_in) begin
                state_nxt = DONE;
            end else if (access_in) begin
                state_nxt = REQ;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                REQ:     if (dmem_ack) state_nxt = DONE;
                DONE:    if (transfer) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Memory port: request held in REQ, address/data come straight from stable payload registers.
    always_comb begin
        dmem_req   = mem_valid && (state == REQ);
        dmem_wr    = dmem_we_r;
        dmem_addr  = {alu_result_r[AW-1:2], 2'b00};
        dmem_wdata = rt_r;
    end

    // Writeback value select and WB/bypass qualifiers.
    always_comb begin
        case (rd_mux_sel_r)
            2'b00:   rd_data = alu_result_r;
            2'b01:   rd_data = load_buf;
            2'b10:   rd_data = hi_r;
            default: rd_data = lo_r;
        endcase
        bypass_mem       = rd_data;
        rdc_mem          = rdc_r;
        rf_we            = mem_valid && rf_we_r && !adel_r;
        mem_load_pending = mem_valid && lw_instr_r && (state != DONE);
        mem_rdc_valid    = rf_we && bypass_rdc_valid_r && !mem_load_pending;
    end

endmodule

// File: tb/tb_pipe_mem.sv
// tb/tb_pipe_mem.sv - directed self-checking bench for pipe_mem
module tb_pipe_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_mem_validto;
    logic        mem_allowin;
    logic        wb_allowin;
    logic        mem_wb_validto;
    logic [31:0] alu_result_in;
    logic [31:0] rt_in;
    logic [4:0]  rdc_in;
    logic [1:0]  rd_mux_sel_in;
    logic        dmem_we_in;
    logic        lw_instr_in;
    logic        rf_we_in;
    logic        bypass_rdc_valid_in;
    logic [31:0] lo_in;
    logic [31:0] hi_in;
    logic        dmem_req;
    logic        dmem_wr;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] rd_data;
    logic [4:0]  rdc_mem;
    logic        rf_we;
    logic [31:0] bypass_mem;
    logic        mem_rdc_valid;
    logic        mem_load_pending;
`ifdef PIPE_MEM_ALIGN_CHK_EN
    logic        mem_adel;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_mem #(.AW(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .exe_mem_validto     (exe_mem_validto),
        .mem_allowin         (mem_allowin),
        .wb_allowin          (wb_allowin),
        .mem_wb_validto      (mem_wb_validto),
        .alu_result_in       (alu_result_in),
        .rt_in               (rt_in),
        .rdc_in              (rdc_in),
        .rd_mux_sel_in       (rd_mux_sel_in),
        .dmem_we_in          (dmem_we_in),
        .lw_instr_in         (lw_instr_in),
        .rf_we_in            (rf_we_in),
        .bypass_rdc_valid_in (bypass_rdc_valid_in),
        .lo_in               (lo_in),
        .hi_in               (hi_in),
        .dmem_req            (dmem_req),
        .dmem_wr             (dmem_wr),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_ack            (dmem_ack),
        .dmem_rdata          (dmem_rdata),
        .rd_data             (rd_data),
        .rdc_mem             (rdc_mem),
        .rf_we               (rf_we),
        .bypass_mem          (bypass_mem),
        .mem_rdc_valid       (mem_rdc_valid),
`ifdef PIPE_MEM_ALIGN_CHK_EN
        .mem_adel            (mem_adel),
`endif
        .mem_load_pending    (mem_load_pending)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] rdc, input logic [1:0] sel, input logic we,
                         input logic lw, input logic rfwe, input logic byp);
        exe_mem_validto     = v;
        alu_result_in       = alu;
        rt_in               = rt;
        rdc_in              = rdc;
        rd_mux_sel_in       = sel;
        dmem_we_in          = we;
        lw_instr_in         = lw;
        rf_we_in            = rfwe;
        bypass_rdc_valid_in = byp;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_allowin = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        lo_in = 32'h1111_0000; hi_in = 32'h2222_0000;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got %b want 1", mem_allowin); end
        n_checks++; if (mem_wb_validto !== 1'b0) begin n_fail++; $display("FAIL reset_validto got %b want 0", mem_wb_validto); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", dmem_req); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
        n_checks++; if (mem_rdc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdc_valid got %b want 0", mem_rdc_valid); end
        n_checks++; if (mem_load_pending !== 1'b0) begin n_fail++; $display("FAIL reset_load_pending got %b want 0", mem_load_pending); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h1234, 32'h0, 5'd7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (mem_wb_validto !== 1'b1) begin n_fail++; $display("FAIL alu_validto got %b want 1", mem_wb_validto); end
        n_checks++; if (rd_data !== 32'h1234) begin n_fail++; $display("FAIL alu_rd_data got %h want 00001234", rd_data); end
        n_checks++; if (bypass_mem !== 32'h1234) begin n_fail++; $display("FAIL alu_bypass got %h want 00001234", bypass_mem); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req got %b want 0", dmem_req); end
        n_checks++; if (rdc_mem !== 5'd7 || rf_we !== 1'b1 || mem_rdc_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_ctl got rdc=%0d we=%b rv=%b want 7 1 1", rdc_mem, rf_we, mem_rdc_valid); end
        cyc();
        n_checks++; if (mem_wb_validto !== 1'b0) begin n_fail++; $display("FAIL alu_drained got %b want 0", mem_wb_validto); end
        // HI and LO selects
        drive(1'b1, 32'h0, 32'h0, 5'd3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 32'h0, 32'h0, 5'd3, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (rd_data !== 32'h2222_0000) begin n_fail++; $display("FAIL hi_sel got %h want 22220000", rd_data); end
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (rd_data !== 32'h1111_0000) begin n_fail++; $display("FAIL lo_sel got %h want 11110000", rd_data); end
        cyc();
    endtask

    task automatic test_load();
        int req_cycles = 0;
        drive(1'b1, 32'h40, 32'h0, 5'd9, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dmem_wr !== 1'b0 || dmem_addr !== 32'h40) begin n_fail++; $display("FAIL load_port got wr=%b addr=%h want 0 00000040", dmem_wr, dmem_addr); end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1; end
            if (dmem_req === 1'b1) req_cycles++;
            n_checks++; if (mem_load_pending !== 1'b1 || mem_allowin !== 1'b0 || mem_rdc_valid !== 1'b0) begin n_fail++; $display("FAIL load_wait%0d got pend=%b allow=%b rv=%b want 1 0 0", i, mem_load_pending, mem_allowin, mem_rdc_valid); end
            cyc();
        end
        dmem_ack = 1'b0; dmem_rdata = 32'h0; #1;
        n_checks++; if (req_cycles !== 3) begin n_fail++; $display("FAIL load_req_cycles got %0d want 3", req_cycles); end
        n_checks++; if (mem_wb_validto !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_done got vt=%b req=%b want 1 0", mem_wb_validto, dmem_req); end
        n_checks++; if (rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rd_data got %h want deadbeef", rd_data); end
        n_checks++; if (mem_load_pending !== 1'b0 || mem_rdc_valid !== 1'b1 || rf_we !== 1'b1) begin n_fail++; $display("FAIL load_wb_ctl got pend=%b rv=%b we=%b want 0 1 1", mem_load_pending, mem_rdc_valid, rf_we); end
        cyc();
        n_checks++; if (mem_wb_validto !== 1'b0) begin n_fail++; $display("FAIL load_drained got %b want 0", mem_wb_validto); end
    endtask

    task automatic test_store();
        drive(1'b1, 32'h80, 32'h55AA, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        // Upstream inputs change while waiting; the port must not follow them.
        drive(1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (dmem_req !== 1'b1 || dmem_wr !== 1'b1 || dmem_addr !== 32'h80 || dmem_wdata !== 32'h55AA) begin n_fail++; $display("FAIL store_port%0d got req=%b wr=%b addr=%h wd=%h want 1 1 00000080 000055aa", i, dmem_req, dmem_wr, dmem_addr, dmem_wdata); end
            if (i == 1) begin dmem_ack = 1'b1; #1; end
            cyc();
        end
        dmem_ack = 1'b0; #1;
        n_checks++; if (mem_wb_validto !== 1'b1 || rf_we !== 1'b0 || mem_load_pending !== 1'b0) begin n_fail++; $display("FAIL store_done got vt=%b we=%b pend=%b want 1 0 0", mem_wb_validto, rf_we, mem_load_pending); end
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(k + 1), 32'h0, 5'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
            n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allow%0d got %b want 1", k, mem_allowin); end
            cyc();
            n_checks++; if (mem_wb_validto !== 1'b1 || rd_data !== 32'(k + 1)) begin n_fail++; $display("FAIL b2b_out%0d got vt=%b data=%h want 1 %h", k, mem_wb_validto, rd_data, 32'(k + 1)); end
        end
        wb_allowin = 1'b0;
        drive(1'b1, 32'd5, 32'h0, 5'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (mem_allowin !== 1'b0 || mem_wb_validto !== 1'b1 || rd_data !== 32'd4) begin n_fail++; $display("FAIL stall%0d got allow=%b vt=%b data=%h want 0 1 00000004", i, mem_allowin, mem_wb_validto, rd_data); end
            cyc();
        end
        wb_allowin = 1'b1; #1;
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", mem_allowin); end
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (rd_data !== 32'd5 || mem_wb_validto !== 1'b1) begin n_fail++; $display("FAIL stall_next got data=%h vt=%b want 00000005 1", rd_data, mem_wb_validto); end
        cyc();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 32'h42, 32'h0, 5'd4, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_MEM_ALIGN_CHK_EN
        n_checks++; if (dmem_req !== 1'b0 || mem_adel !== 1'b1 || rf_we !== 1'b0 || mem_wb_validto !== 1'b1) begin n_fail++; $display("FAIL adel got req=%b adel=%b we=%b vt=%b want 0 1 0 1", dmem_req, mem_adel, rf_we, mem_wb_validto); end
        cyc();
        n_checks++; if (mem_adel !== 1'b0) begin n_fail++; $display("FAIL adel_clear got %b want 0", mem_adel); end
`else
        n_checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h40) begin n_fail++; $display("FAIL unaligned_addr got req=%b addr=%h want 1 00000040", dmem_req, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D; #1;
        cyc();
        dmem_ack = 1'b0; #1;
        n_checks++; if (mem_wb_validto !== 1'b1 || rd_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL fast_ack got vt=%b data=%h want 1 0badf00d", mem_wb_validto, rd_data); end
        cyc();
`endif
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 32'h100, 32'h0, 5'd2, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req got %b want 1", dmem_req); end
        rst = 1'b1;
        cyc();
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_CAFE; #1;
        n_checks++; if (dmem_req !== 1'b0 || mem_wb_validto !== 1'b0 || mem_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after got req=%b vt=%b allow=%b want 0 0 1", dmem_req, mem_wb_validto, mem_allowin); end
        cyc();
        dmem_ack = 1'b0; #1;
        n_checks++; if (mem_wb_validto !== 1'b0 || dmem_req !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack got vt=%b req=%b we=%b want 0 0 0", mem_wb_validto, dmem_req, rf_we); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
